// File: rtl/ar_envelope_pkg.sv
// Shared audio definitions: envelope width, sample width default,
// AR envelope states and the envelope-to-gain mapping.
package ar_envelope_pkg;

    localparam int ENV_WIDTH    = 16;
    localparam int GAIN_WIDTH   = 9;
    localparam int BITDEPTH_DEF = 14;

    localparam logic [ENV_WIDTH-1:0] ENV_MAX = '1;

    typedef enum logic [1:0] {
        IDLE,
        ATTACK,
        SUSTAIN,
        RELEASE
    } env_state_e;

    // Full-scale envelope maps to 256 so the multiply is exactly unity.
    function automatic logic [GAIN_WIDTH-1:0] env_gain(
        input logic [ENV_WIDTH-1:0] env
    );
        if (env == ENV_MAX) begin
            return GAIN_WIDTH'(256);
        end
        return {1'b0, env[ENV_WIDTH-1 -: 8]};
    endfunction

endpackage

// File: rtl/ar_envelope_if.sv
// Sample/control bundle between the voice path and the AR envelope.
interface ar_envelope_if
    import ar_envelope_pkg::*;
#(
    parameter int BITDEPTH = BITDEPTH_DEF
);

    logic signed [BITDEPTH-1:0] in;
    logic        [7:0]          envelope_attack;
    logic        [7:0]          envelope_decay;
    logic                       gate;
    logic signed [BITDEPTH-1:0] out;

    modport master (
        output in,
        output envelope_attack,
        output envelope_decay,
        output gate,
        input  out
    );

    modport slave (
        input  in,
        input  envelope_attack,
        input  envelope_decay,
        input  gate,
        output out
    );

endinterface

// File: rtl/ar_env_gen.sv
// AR state machine with saturating envelope accumulator; emits 9-bit gain.
module ar_env_gen
    import ar_envelope_pkg::*;
(
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  gate_i,
    input  logic [7:0]            attack_i,
    input  logic [7:0]            decay_i,
    output logic [GAIN_WIDTH-1:0] gain_o
);

    env_state_e           state_q, state_d;
    logic [ENV_WIDTH-1:0] env_q, env_d;
    logic [ENV_WIDTH:0]   up_sum;
    logic [ENV_WIDTH-1:0] up_env;
    logic [ENV_WIDTH-1:0] dn_env;

    // A zero rate means an instantaneous jump to the rail.
    always_comb begin
        up_sum = {1'b0, env_q} + (ENV_WIDTH+1)'(attack_i);
        up_env = up_sum[ENV_WIDTH-1:0];
        if (attack_i == 8'd0 || up_sum[ENV_WIDTH]) begin
            up_env = ENV_MAX;
        end
        dn_env = env_q - ENV_WIDTH'(decay_i);
        if (decay_i == 8'd0 || env_q < ENV_WIDTH'(decay_i)) begin
            dn_env = '0;
        end
    end

    always_comb begin
        state_d = state_q;
        env_d   = env_q;
        unique case (state_q)
            IDLE: begin
                env_d = '0;
                if (gate_i) begin
                    env_d   = up_env;
                    state_d = (up_env == ENV_MAX) ? SUSTAIN : ATTACK;
                end
            end
            ATTACK, SUSTAIN, RELEASE: begin
                if (gate_i) begin
                    env_d   = up_env;
                    state_d = (up_env == ENV_MAX) ? SUSTAIN : ATTACK;
                end else begin
                    env_d   = dn_env;
                    state_d = (dn_env == '0) ? IDLE : RELEASE;
                end
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            env_q   <= '0;
        end else begin
            state_q <= state_d;
            env_q   <= env_d;
        end
    end

    assign gain_o = env_gain(env_q);

endmodule

// File: rtl/ar_envelope.sv
// Attack/release amplitude envelope: scales each sample by the envelope
// gain with a registered signed multiply and arithmetic shift.
module ar_envelope
    import ar_envelope_pkg::*;
#(
    parameter int BITDEPTH = BITDEPTH_DEF
) (
    input  logic          sample_clock,
    input  logic          rst,
    ar_envelope_if.slave  bus
);

    logic [GAIN_WIDTH-1:0]              gain;
    logic signed [BITDEPTH+GAIN_WIDTH:0] prod;
    logic signed [BITDEPTH-1:0]         out_q, out_d;

    ar_env_gen u_gen (
        .clk_i    (sample_clock),
        .rst_i    (rst),
        .gate_i   (bus.gate),
        .attack_i (bus.envelope_attack),
        .decay_i  (bus.envelope_decay),
        .gain_o   (gain)
    );

    // Gain is unsigned, so widen it with a zero sign bit before multiplying.
    always_comb begin
        prod  = $signed(bus.in) * $signed({1'b0, gain});
        out_d = BITDEPTH'(prod >>> 8);
    end

    always_ff @(posedge sample_clock or posedge rst) begin
        if (rst) begin
            out_q <= '0;
        end else begin
            out_q <= out_d;
        end
    end

    assign bus.out = out_q;

endmodule

// File: tb/tb_ar_envelope.sv
// Self-checking bench for ar_envelope against an arithmetic envelope model.
module tb_ar_envelope;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int checks = 0;
    int errors = 0;
    int env_m  = 0;
    int exp_out;

    ar_envelope_if #(.BITDEPTH(14)) bus ();

    ar_envelope #(.BITDEPTH(14)) dut (
        .sample_clock (clk),
        .rst          (rst),
        .bus          (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %0d want %0d", tag, got, want);
        end
    endtask

    function automatic int gain_of(input int e);
        return (e == 65535) ? 256 : (e / 256);
    endfunction

    // floor(x * g / 256), rounding toward minus infinity
    function automatic int scale(input int x, input int g);
        int p;
        p = x * g;
        if (p >= 0) return p / 256;
        return -((-p + 255) / 256);
    endfunction

    function automatic int next_env(input int e, input bit g,
                                    input int a, input int d);
        if (g) begin
            if (a == 0 || e + a > 65535) return 65535;
            return e + a;
        end
        if (d == 0 || e - d < 0) return 0;
        return e - d;
    endfunction

    task automatic step(input int x, input bit g, input int a, input int d,
                        input string tag);
        logic [31:0] xv;
        xv = x;
        bus.in              = xv[13:0];
        bus.gate            = g;
        bus.envelope_attack = a[7:0];
        bus.envelope_decay  = d[7:0];
        @(posedge clk);
        exp_out = scale(x, gain_of(env_m));
        env_m   = next_env(env_m, g, a, d);
        #1;
        chk(tag, int'(bus.out), exp_out);
    endtask

    task automatic do_reset();
        bus.in   = 14'sd4096;
        bus.gate = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        chk("rst_async", int'(bus.out), 0);
        env_m = 0;
        @(posedge clk);
        #1;
        chk("rst_hold", int'(bus.out), 0);
        bus.gate = 1'b0;
        #2;
        rst = 1'b0;
    endtask

    initial begin
        bit g;
        int a, d, x;
        bus.in              = '0;
        bus.gate            = 1'b0;
        bus.envelope_attack = '0;
        bus.envelope_decay  = '0;
        #1;
        chk("rst_init", int'(bus.out), 0);
        #12;
        rst = 1'b0;
        for (int i = 0; i < 20; i++) step(4096, 1'b0, 240, 48, "idle_zero");

        // attack to unity, then release to zero
        for (int i = 0; i < 275; i++) step(4096, 1'b1, 240, 48, "attack");
        step(4096, 1'b1, 240, 48, "sustain");
        chk("unity", int'(bus.out), 4096);
        step(-4096, 1'b1, 240, 48, "sustain_neg");
        step(-4096, 1'b1, 240, 48, "sustain_neg");
        chk("unity_neg", int'(bus.out), -4096);
        step(4096, 1'b0, 240, 48, "rel_first");
        step(4096, 1'b0, 240, 48, "rel_second");
        chk("rel_gain255", int'(bus.out), 4080);
        for (int i = 2; i < 1366; i++) step(4096, 1'b0, 240, 48, "release");
        step(4096, 1'b0, 240, 48, "rel_end");
        chk("rel_zero", int'(bus.out), 0);
        for (int i = 0; i < 5; i++) step(4096, 1'b0, 240, 48, "idle_after");

        // mid-attack reversal
        do_reset();
        for (int i = 0; i < 100; i++) step(4096, 1'b1, 240, 48, "mid_att");
        step(4096, 1'b0, 240, 48, "mid_rev");
        chk("mid_gain93", int'(bus.out), 1488);
        for (int i = 0; i < 9; i++) step(4096, 1'b0, 240, 48, "mid_rel");
        step(4096, 1'b1, 240, 48, "mid_back");
        chk("mid_gain91", int'(bus.out), 1456);
        step(4096, 1'b1, 240, 48, "mid_rise");
        chk("mid_rise", int'(bus.out), 1472);

        // signed input at gain 93
        do_reset();
        for (int i = 0; i < 100; i++) step(-4096, 1'b1, 240, 48, "neg_att");
        step(-4096, 1'b1, 240, 48, "neg_g93");
        chk("neg_gain93", int'(bus.out), -1488);

        // zero rates
        do_reset();
        step(3000, 1'b1, 0, 0, "zatt_edge");
        step(3000, 1'b1, 0, 0, "zatt_next");
        chk("zero_attack", int'(bus.out), 3000);
        step(3000, 1'b0, 0, 0, "zdec_edge");
        step(3000, 1'b0, 0, 0, "zdec_next");
        chk("zero_decay", int'(bus.out), 0);

        // gate toggling every edge
        for (int i = 0; i < 40; i++) step(-5000, i[0], 37, 11, "toggle");

        // randomized runs
        g = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 31) == 0) g = ~g;
            a = ($urandom_range(0, 15) == 0) ? 0 : int'($urandom_range(1, 255));
            d = ($urandom_range(0, 15) == 0) ? 0 : int'($urandom_range(1, 255));
            x = int'($urandom_range(0, 16383)) - 8192;
            step(x, g, a, d, "random");
            if (i == 1500) do_reset();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
